// File: rtl/instruction_fetch_unit.sv
// Program memory, loader and program counter feeding the control unit.
// Optional IFU_WRAP_ON_END_EN: loop back to address 0 instead of halting.
module instruction_fetch_unit #(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [15:0]       load_data,
  input  logic              load_last,
  input  logic              run,
  input  logic              stop,
  input  logic              pc_write_enable,
  input  logic              pc_source_mux_select,
  output logic [15:0]       instruction,
  output logic [ADDR_W-1:0] pc,
  output logic              running,
  output logic              halted
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [15:0] NOP = 16'hC000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_HALT
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_load_addr;
  logic [ADDR_W:0]   r_prog_len;
  logic [15:0]       r_instr;
  logic [15:0]       r_mem [DEPTH];

  logic              w_accept;
  logic [ADDR_W-1:0] w_off;
  logic [ADDR_W-1:0] w_next;
  logic [ADDR_W:0]   w_pc_inc;
  logic              w_end;

  assign w_accept = (r_state == S_LOAD) && load_valid;
  assign w_off    = ADDR_W'($signed(r_instr[6:0]));
  assign w_next   = pc_source_mux_select ? (r_pc + 1'b1 + w_off)
                                         : (r_pc + 1'b1);
  assign w_pc_inc = {1'b0, r_pc} + {{ADDR_W{1'b0}}, 1'b1};
  assign w_end    = !pc_source_mux_select && (w_pc_inc == r_prog_len);

  // Program storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_mem[r_load_addr] <= load_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_load_addr <= '0;
      r_prog_len  <= '0;
      r_instr     <= NOP;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (load_start) begin
            r_state     <= S_LOAD;
            r_load_addr <= '0;
          end else if (run) begin
            r_pc <= '0;
            if (r_prog_len == '0) begin
              r_state <= S_HALT;
              r_instr <= NOP;
            end else begin
              r_state <= S_RUN;
              r_instr <= r_mem[0];
            end
          end
        end
        S_LOAD: begin
          if (load_valid) begin
            r_load_addr <= r_load_addr + 1'b1;
            if (load_last || (&r_load_addr)) begin
              r_prog_len <= {1'b0, r_load_addr}
                          + {{ADDR_W{1'b0}}, 1'b1};
              r_state    <= S_IDLE;
            end
          end
        end
        S_RUN: begin
          if (stop) begin
            r_state <= S_IDLE;
            r_instr <= NOP;
          end else if (pc_write_enable) begin
            if (w_end) begin
`ifdef IFU_WRAP_ON_END_EN
              r_pc    <= '0;
              r_instr <= r_mem[0];
`else
              r_state <= S_HALT;
              r_instr <= NOP;
`endif
            end else begin
              r_pc    <= w_next;
              r_instr <= r_mem[w_next];
            end
          end
        end
        S_HALT: begin
          r_instr <= NOP;
          if (stop) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign load_ready  = (r_state == S_LOAD);
  assign running     = (r_state == S_RUN);
  assign halted      = (r_state == S_HALT);
  assign instruction = r_instr;
  assign pc          = r_pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit (ADDR_W=8 and ADDR_W=4).
module tb_instruction_fetch_unit;

`ifdef IFU_WRAP_ON_END_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        pc_we, pc_sel;
  logic        run, stop;

  logic        a_start, a_valid, a_ready, a_last;
  logic [15:0] a_data, a_instr;
  logic [7:0]  a_pc;
  logic        a_running, a_halted;

  logic        b_start, b_valid, b_ready, b_last;
  logic        b_run;
  logic [15:0] b_data, b_instr;
  logic [3:0]  b_pc;
  logic        b_running, b_halted;

  int checks = 0;
  int errors = 0;

  logic [15:0] prog8 [8];

  always #5 clock = ~clock;

  instruction_fetch_unit #(.ADDR_W(8)) u_dut (
    .clock(clock), .reset(reset),
    .load_start(a_start), .load_valid(a_valid),
    .load_ready(a_ready), .load_data(a_data),
    .load_last(a_last), .run(run), .stop(stop),
    .pc_write_enable(pc_we),
    .pc_source_mux_select(pc_sel),
    .instruction(a_instr), .pc(a_pc),
    .running(a_running), .halted(a_halted)
  );

  instruction_fetch_unit #(.ADDR_W(4)) u_dut4 (
    .clock(clock), .reset(reset),
    .load_start(b_start), .load_valid(b_valid),
    .load_ready(b_ready), .load_data(b_data),
    .load_last(b_last), .run(b_run), .stop(stop),
    .pc_write_enable(pc_we),
    .pc_source_mux_select(pc_sel),
    .instruction(b_instr), .pc(b_pc),
    .running(b_running), .halted(b_halted)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Three idle cycles then one advance, like the 4-phase sequencer.
  task automatic adv(input logic sel);
    tick(); tick(); tick();
    pc_sel = sel;
    pc_we  = 1'b1;
    tick();
    pc_we  = 1'b0;
    pc_sel = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pc_we = 0; pc_sel = 0;
    run = 0; stop = 0;
    a_start = 0; a_valid = 0; a_last = 0; a_data = '0;
    b_start = 0; b_valid = 0; b_last = 0; b_data = '0;
    b_run = 0;
    for (int i = 0; i < 8; i++) prog8[i] = 16'h1000 + 16'(i);
    prog8[4] = 16'hC07D;
    tick(); tick();
    reset = 1'b0;
    check("rst_pc", 32'(a_pc), 32'h0);
    check("rst_instr", 32'(a_instr), 32'hC000);
    check("rst_ready", 32'(a_ready), 32'h0);
    check("rst_running", 32'(a_running), 32'h0);
    check("rst_halted", 32'(a_halted), 32'h0);

    // Run with nothing loaded halts immediately.
    run = 1; tick(); run = 0;
    check("empty_halted", 32'(a_halted), 32'h1);
    check("empty_running", 32'(a_running), 32'h0);
    stop = 1; tick(); stop = 0;
    check("empty_stop", 32'(a_halted), 32'h0);

    // Three-word program.
    a_start = 1; tick(); a_start = 0;
    check("ld3_ready", 32'(a_ready), 32'h1);
    a_valid = 1;
    a_data = 16'h0400; tick();
    a_data = 16'h2480; tick();
    a_data = 16'h8000; a_last = 1; tick();
    a_valid = 0; a_last = 0;
    check("ld3_ready_drop", 32'(a_ready), 32'h0);
    run = 1; tick(); run = 0;
    check("p3_running", 32'(a_running), 32'h1);
    check("p3_i0", 32'(a_instr), 32'h0400);
    check("p3_pc0", 32'(a_pc), 32'h0);
    adv(0);
    check("p3_i1", 32'(a_instr), 32'h2480);
    check("p3_pc1", 32'(a_pc), 32'h1);
    adv(0);
    check("p3_i2", 32'(a_instr), 32'h8000);
    adv(0);
    check("p3_end_halted", 32'(a_halted), 32'(!WRAP));
    check("p3_end_instr", 32'(a_instr),
          WRAP ? 32'h0400 : 32'hC000);
    check("p3_end_pc", 32'(a_pc), WRAP ? 32'h0 : 32'h2);
    stop = 1; tick(); stop = 0;
    check("p3_stop_instr", 32'(a_instr), 32'hC000);

    // load_start and run together: load wins; bubbles not written.
    a_start = 1; run = 1; tick(); a_start = 0; run = 0;
    check("bp_ready", 32'(a_ready), 32'h1);
    check("bp_not_run", 32'(a_running), 32'h0);
    for (int i = 0; i < 8; i++) begin
      a_valid = 0; a_data = 16'hDEAD;
      run = (i == 3);
      tick();
      run = 0;
      a_valid = 1; a_data = prog8[i]; a_last = (i == 7);
      tick();
    end
    a_valid = 0; a_last = 0;
    check("bp_ready_drop", 32'(a_ready), 32'h0);
    check("bp_idle", 32'(a_running), 32'h0);
    run = 1; tick(); run = 0;
    check("p8_i0", 32'(a_instr), 32'h1000);
    adv(0); adv(0); adv(0); adv(0);
    check("p8_pc4", 32'(a_pc), 32'h4);
    check("p8_i4", 32'(a_instr), 32'hC07D);
    adv(1);
    check("br_pc", 32'(a_pc), 32'h2);
    check("br_instr", 32'(a_instr), 32'h1002);
    adv(0); adv(0); adv(0); adv(0); adv(0);
    check("p8_pc7", 32'(a_pc), 32'h7);
    check("p8_i7", 32'(a_instr), 32'h1007);
    adv(0);
    check("p8_end_halted", 32'(a_halted), 32'(!WRAP));
    check("p8_end_pc", 32'(a_pc), WRAP ? 32'h0 : 32'h7);
    if (!WRAP) begin
      adv(0);
      check("halt_hold_pc", 32'(a_pc), 32'h7);
      check("halt_instr", 32'(a_instr), 32'hC000);
    end

    // Reset mid-run clears prog_len.
    stop = 1; tick(); stop = 0;
    run = 1; tick(); run = 0;
    adv(0);
    check("mr_pc1", 32'(a_pc), 32'h1);
    reset = 1; tick(); reset = 0;
    check("mr_pc", 32'(a_pc), 32'h0);
    check("mr_instr", 32'(a_instr), 32'hC000);
    check("mr_running", 32'(a_running), 32'h0);
    run = 1; tick(); run = 0;
    check("mr_rerun_halted", 32'(a_halted), 32'h1);
    stop = 1; tick(); stop = 0;

    // ADDR_W=4: full-depth load ends without load_last.
    b_start = 1; tick(); b_start = 0;
    b_valid = 1;
    for (int i = 0; i < 16; i++) begin
      b_data = 16'h5000 + 16'(i);
      tick();
      if (i == 14) check("a4_ready15", 32'(b_ready), 32'h1);
    end
    b_valid = 0;
    check("a4_ready_drop", 32'(b_ready), 32'h0);
    b_run = 1; tick(); b_run = 0;
    check("a4_i0", 32'(b_instr), 32'h5000);
    for (int i = 0; i < 15; i++) adv(0);
    check("a4_pc15", 32'(b_pc), 32'hF);
    check("a4_i15", 32'(b_instr), 32'h500F);
    adv(0);
    check("a4_end_halted", 32'(b_halted), 32'(!WRAP));
    check("a4_end_pc", 32'(b_pc), WRAP ? 32'h0 : 32'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Supplies the 16-bit `instruction` word consumed by the processor control unit and owns the program counter that the control unit's `pc_write_enable` / `pc_source_mux_select` outputs act on. Holds an internal program memory filled through a valid/ready load port, then steps through it in run mode, taking BNE branches when told to. Sits between the external program loader and the control unit; the control unit's 4-phase sequencer drives all PC advances.

## Interface
- `ADDR_W`, 8: program address width; memory depth is 2**ADDR_W words.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `load_start`  in  1  pulse in IDLE: enter LOAD, load address cleared to 0.
- `load_valid`  in  1  load word present.
- `load_ready`  out  1  high only in LOAD.
- `load_data`  in  16  program word.
- `load_last`  in  1  qualifies final word of a load.
- `run`  in  1  pulse in IDLE: start execution at address 0.
- `stop`  in  1  RUN/HALT -> IDLE.
- `pc_write_enable`  in  1  from control unit; advance PC this edge.
- `pc_source_mux_select`  in  1  from control unit; 1 = take branch target.
- `instruction`  out  16  current instruction, registered.
- `pc`  out  ADDR_W  address of `instruction`.
- `running`  out  1  state == RUN.
- `halted`  out  1  state == HALT.

## Operation
- States: IDLE, LOAD, RUN, HALT.
- IDLE: `load_start` -> LOAD; else `run` -> RUN; both same cycle: `load_start` wins.
- LOAD: each `load_valid && load_ready` writes `load_data` to mem[load_addr], load_addr++. Accepted word with `load_last`, or accepted word at address 2**ADDR_W-1, ends load: `prog_len` <= words accepted (ADDR_W+1 bits, max 2**ADDR_W), -> IDLE. `run`, `stop` ignored in LOAD.
- Entering RUN: `pc` <= 0, `instruction` <= mem[0]. If `prog_len` == 0, go to HALT instead.
- RUN, `pc_write_enable`=1: next = `pc_source_mux_select` ? pc + 1 + sext(instruction[6:0]) : pc + 1, modulo 2**ADDR_W. If not branching and pc + 1 == `prog_len` -> end-of-program (see Configuration). Otherwise `pc` <= next, `instruction` <= mem[next].
- Branch target beyond `prog_len` is legal; fetch proceeds from stale/undefined memory (no check).
- HALT: `instruction` forced to 16'hC000 (BNE r0,r0, zero offset; no register write); `pc_write_enable` ignored; `pc` holds.
- `stop` in RUN or HALT -> IDLE, `instruction` <= 16'hC000, `pc` holds.
- `pc_write_enable` outside RUN ignored.

## Timing
- Reset values: state IDLE, `pc` 0, `instruction` 16'hC000, `load_ready` 0, `running` 0, `halted` 0, `prog_len` 0, load_addr 0. Memory contents not reset.
- `load_ready` rises the cycle after `load_start`; one word per cycle at full throughput; drops the cycle after the final accepted word.
- `run` to `running`=1 and `instruction`=mem[0]: 1 cycle.
- `pc_write_enable` edge to new `pc`/`instruction` visible: 1 cycle (same edge updates both; control unit state 00 sees new word).
- End-of-program to `halted`=1: same edge as the would-be PC advance.
- `reset` mid-LOAD or mid-RUN: all state returns to reset values next edge; loaded words already written remain but `prog_len` = 0, so a program must be reloaded.

## Configuration
- `IFU_WRAP_ON_END_EN` defined: end-of-program sets `pc` <= 0, `instruction` <= mem[0], stays in RUN (program loops forever); `halted` never asserts except for `prog_len` == 0.
- Undefined: end-of-program -> HALT as described.

## Test plan
- Load 3 words 16'h0400, 16'h2480, 16'h8000 with `load_last` on third, `run`, pulse `pc_write_enable` every 4th cycle -> `instruction` sequence 0400, 2480, 8000, then `halted`=1, `instruction`=C000, `pc`=2.
- Load 8 words, word 4 = 16'hC07D (offset -3); `pc_source_mux_select`=1 on its advance -> `pc` 4 -> 2, `instruction`=mem[2].
- Backpressure: `load_valid` toggling, `load_start`+`run` same cycle -> LOAD entered, only handshaked words written, `prog_len` matches count.
- With ADDR_W=4, stream 16 words without `load_last` -> load ends after word 15, `prog_len`=16, `load_ready`=0.
- `run` with `prog_len`=0 -> `halted`=1 one cycle later; `reset` asserted mid-RUN -> `pc`=0, `instruction`=C000, IDLE.
- `IFU_WRAP_ON_END_EN` defined, 2-word program -> `pc` 0,1,0,1 on successive advances, `halted` stays 0.
